// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction fetch block: FSM encoding, HALT opcode
// and the field layout of a 20-bit program word.
package instr_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    ISSUE  = 2'd2,
    HALTED = 2'd3
  } state_e;

  localparam logic [3:0] OP_HALT = 4'hF;

  localparam int WORD_W = 20;
  localparam int OP_MSB = 19;
  localparam int OP_LSB = 16;
  localparam int A_MSB  = 15;
  localparam int A_LSB  = 8;
  localparam int B_MSB  = 7;
  localparam int B_LSB  = 0;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/instr_fetch_prog_mem.sv
// Program memory: one synchronous write port and one registered read port.
// The read register clears on reset; the storage array keeps its contents.
module prog_mem #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int W     = 20
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] rdata_d, rdata_q;

  // NOTE: the array has no reset so the program survives rst and maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  // NOTE: combinational blocks assign every output a default first, so no latch is inferred.
  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = mem_q[raddr];
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdata_q <= '0;
    else     rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch/issue FSM with pc and saturating issue counter.
// Optional macro FETCH_LOOP_EN: wrap pc to 0 after the last word instead of halting.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [19:0]   prog_data,
  input  logic          issue_ready,
  output logic          issue_valid,
  output logic [3:0]    instr,
  output logic [7:0]    inA,
  output logic [7:0]    inB,
  output logic          busy,
  output logic          halted,
  output logic [AW-1:0] pc,
  output logic [7:0]    issue_count
);

  localparam logic [AW-1:0] PC_LAST = AW'(DEPTH - 1);

  state_e              state_d, state_q;
  logic [AW-1:0]       pc_d, pc_q;
  logic [7:0]          cnt_d, cnt_q;
  logic                rd_en;
  logic                mem_we;
  logic [WORD_W-1:0]   rdata;

  assign busy   = (state_q == FETCH) || (state_q == ISSUE);
  assign halted = (state_q == HALTED);
  assign mem_we = prog_we && !busy;

  prog_mem #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .W     (WORD_W)
  ) u_prog_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (mem_we),
    .waddr (prog_addr),
    .wdata (prog_data),
    .re    (rd_en),
    .raddr (pc_q),
    .rdata (rdata)
  );

  assign instr = rdata[OP_MSB:OP_LSB];
  assign inA   = rdata[A_MSB:A_LSB];
  assign inB   = rdata[B_MSB:B_LSB];

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    cnt_d       = cnt_q;
    rd_en       = 1'b0;
    issue_valid = 1'b0;
    case (state_q)
      IDLE, HALTED: begin
        if (start) begin
          pc_d    = '0;
          cnt_d   = '0;
          state_d = FETCH;
        end
      end
      FETCH: begin
        rd_en   = 1'b1;
        state_d = ISSUE;
      end
      ISSUE: begin
        // The fetched word is only visible once registered, so a HALT op is
        // recognised here and retired without ever raising issue_valid.
        if (instr == OP_HALT) begin
          state_d = HALTED;
        end else begin
          issue_valid = 1'b1;
          if (issue_ready) begin
            cnt_d = sat_inc8(cnt_q);
            if (pc_q == PC_LAST) begin
`ifdef FETCH_LOOP_EN
              pc_d    = '0;
              state_d = FETCH;
`else
              state_d = HALTED;
`endif
            end else begin
              pc_d    = pc_q + AW'(1);
              state_d = FETCH;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pc          = pc_q;
  assign issue_count = cnt_q;

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter DEPTH, default 16, meaning the number of program memory words.
REQ-002 SHALL have parameter AW, default 4, meaning the address width (log2 DEPTH).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state is updated on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port start, input, 1 bit: a one-cycle request to begin execution at address 0.
REQ-006 SHALL have port prog_we, input, 1 bit: program memory write enable.
REQ-007 SHALL have port prog_addr, input, AW bits: program memory write address.
REQ-008 SHALL have port prog_data, input, 20 bits, packed as {op[19:16], A[15:8], B[7:0]}.
REQ-009 SHALL have port issue_ready, input, 1 bit: the downstream execute stage accepts the issued instruction.
REQ-010 SHALL have port issue_valid, output, 1 bit: instr, inA and inB hold a valid instruction.
REQ-011 SHALL have ports instr (output, 4 bits), inA (output, 8 bits) and inB (output, 8 bits): the issued operation and its operands.
REQ-012 SHALL have port busy, output, 1 bit: high in states FETCH and ISSUE.
REQ-013 SHALL have port halted, output, 1 bit: high in state HALTED.
REQ-014 SHALL have port pc, output, AW bits: the current program counter.
REQ-015 SHALL have port issue_count, output, 8 bits: the number of accepted issues since the last start.

Function
REQ-016 SHALL implement a four-state FSM: IDLE, FETCH, ISSUE, HALTED.
REQ-017 In IDLE or HALTED, start SHALL clear pc and issue_count and enter FETCH.
REQ-018 In FETCH, the block SHALL perform a registered read of mem[pc] into instr, inA and inB, then enter ISSUE; if the read op equals 4'hF (HALT), it SHALL instead enter HALTED and not issue.
REQ-019 In ISSUE, issue_valid SHALL be 1, and instr, inA and inB SHALL remain stable until issue_ready is sampled high.
REQ-020 On an accepted issue (ISSUE state with issue_ready=1), issue_count SHALL increment, saturating at 255.
REQ-021 On an accepted issue with pc < DEPTH-1, pc SHALL increment and the FSM SHALL return to FETCH.
REQ-022 On an accepted issue with pc = DEPTH-1, behaviour SHALL follow REQ-030/REQ-031.
REQ-023 Latency SHALL be: start high in cycle n gives issue_valid=1 in cycle n+2; an accept in cycle m gives the next issue_valid in cycle m+2 (issue_valid is 0 in the intervening FETCH cycle).
REQ-024 start SHALL be ignored while busy=1.
REQ-025 prog_we SHALL write mem[prog_addr] only in IDLE or HALTED; writes while busy SHALL be dropped.
REQ-026 When start and prog_we coincide in IDLE, the write SHALL complete, and the FETCH of the following cycle SHALL read the new data if the write address is 0.
REQ-027 issue_ready while issue_valid=0 SHALL have no effect.

Reset
REQ-028 Asserting rst SHALL immediately force state=IDLE, pc=0, issue_count=0, issue_valid=0, instr=0, inA=0, inB=0, busy=0 and halted=0, including mid-ISSUE; any pending issue SHALL be lost.
REQ-029 Program memory contents SHALL NOT be cleared by rst.

Configuration
REQ-030 With FETCH_LOOP_EN defined, an accepted issue at pc = DEPTH-1 SHALL wrap pc to 0 and enter FETCH; execution SHALL end only at a HALT op.
REQ-031 Without FETCH_LOOP_EN, an accepted issue at pc = DEPTH-1 SHALL enter HALTED with pc held at DEPTH-1.

Structure
REQ-032 A shared package SHALL hold: the state encoding (IDLE=0, FETCH=1, ISSUE=2, HALTED=3), OP_HALT=4'hF, and the prog_data field offsets.
REQ-033 Program memory SHALL be a sub-module, prog_mem (one synchronous write port, one registered read port); the FSM, pc and counter SHALL reside in instr_fetch.

Verification
REQ-034 Load mem[0]={0,8'h05,8'h03}, mem[1]={1,8'h09,8'h04}, mem[2]={F,0,0}; start, with issue_ready tied to 1 -> two issues, (0,05,03) then (1,09,04); then halted=1, issue_count=2, pc=2.
REQ-035 Hold issue_ready=0 for 5 cycles during an ISSUE -> issue_valid stays 1 and the outputs stay unchanged; the accept occurs on the cycle issue_ready rises.
REQ-036 Fill all 16 words with non-HALT ops; start -> without FETCH_LOOP_EN, halted after 16 issues with pc=15; with FETCH_LOOP_EN, the 17th issue equals mem[0] and issue_count reaches 17.
REQ-037 Assert rst mid-ISSUE -> the same cycle shows issue_valid=0 and pc=0; a subsequent start re-executes from mem[0] with the original program intact.
REQ-038 While busy, pulse prog_we to address 1 and pulse start -> the memory is unchanged and the sequence continues unaffected.
REQ-039 Loop program without HALT under FETCH_LOOP_EN for 300 accepts -> issue_count saturates at 255.
